jedro_1_clint: RTL and testbench
================================

// Module: jedro_1_clint
// PURPOSE
//  Core-local interruptor: memory-mapped machine timer (mtime/mtimecmp) and software-interrupt
//  register (msip). Sits on the data bus as a slave behind the LSU; drives the timer and software
//  interrupt lines sampled by the CSR unit into mip.MTIP / mip.MSIP. Single hart.
// PARAMETERS
//  DATA_WIDTH   32   bus data width; only 32 supported
//  TICK_DIV     1    clk_i cycles per mtime increment; 1 = every cycle, legal range 1..65535
// PORTS
//  clk_i        in   1    clock; all state on rising edge
//  rstn_i       in   1    asynchronous active-low reset
//  req_i        in   1    bus request, single-cycle pulse per access
//  we_i         in   1    1 = write, 0 = read; qualified by req_i
//  addr_i       in   16   byte offset within CLINT window
//  wdata_i      in   32   write data
//  be_i         in   4    byte enables for writes
//  rvalid_o     out  1    response valid, exactly one cycle after each req_i
//  rdata_o      out  32   read data, valid with rvalid_o (0 for writes and errors)
//  err_o        out  1    access error, valid with rvalid_o
//  timer_irq_o  out  1    machine timer interrupt pending (to CSR timer_irq_i)
//  sw_irq_o     out  1    machine software interrupt pending (to CSR sw_irq_i)
// BEHAVIOUR
//  Reset (async assert, sync release): mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0,
//   prescaler=0, rvalid_o=0, rdata_o=0, err_o=0, timer_irq_o=0, sw_irq_o=0. Reset mid-access drops it.
//  Map (word-aligned): 0x0000 msip (bit0 RW, bits31:1 read 0, write ignored);
//   0x4000 mtimecmp[31:0]; 0x4004 mtimecmp[63:32]; 0xBFF8 mtime[31:0]; 0xBFFC mtime[63:32].
//  Bus: accept every req_i (no stall); response registered: rvalid_o=1 next cycle, else 0.
//   Writes apply byte-wise per be_i at the request edge. Reads return value at request edge.
//   addr_i[1:0]!=0 or unmapped offset -> err_o=1, rdata_o=0, no state change.
//   Write with be_i=0 to a mapped word: no change, err_o=0.
//  Prescaler: counts 0..TICK_DIV-1 each cycle; mtime+=1 (64-bit, wraps 2^64-1 -> 0) when it
//   reaches TICK_DIV-1 and then returns to 0. TICK_DIV=1 -> increment every cycle.
//  Write vs tick same cycle: bus write to either mtime half wins over the increment for the
//   whole 64-bit register (written half takes wdata, other half holds; no carry applied).
//   Prescaler is not reset by mtime writes.
//  timer_irq_o: registered, = (mtime >= mtimecmp) unsigned 64-bit, evaluated on next-state values;
//   asserts the cycle after the compare becomes true, stays until mtimecmp raised or mtime
//   written below. Level-sensitive; no clear-on-read.
//  sw_irq_o: registered copy of msip; follows write one cycle after request edge.
//  64-bit updates are two 32-bit writes, no atomicity; software writes mtimecmp hi=all-ones
//   first to avoid spurious irq (transient matches are visible, by design).
//  Reads of mtime hi/lo are not latched together; software re-reads hi to detect carry.
// TESTING
//  Reset, TICK_DIV=1: idle 10 cycles -> read 0xBFF8 returns 10 +/-1 fixed offset, timer_irq_o=0.
//  Write mtimecmp lo=20, hi=0 -> timer_irq_o rises the cycle after mtime reaches 20; write
//   mtimecmp hi=1 -> timer_irq_o falls next cycle.
//  Write mtime lo=FFFF_FFFF, hi=0 -> after 1 tick hi=1, lo=0 (carry); set both=all-ones ->
//   next tick reads 0/0 (wrap), irq drops against mtimecmp=all-ones.
//  Write 0x0000=1 -> sw_irq_o=1 next cycle; write 0 -> 0; read returns 1/0, bits31:1 zero.
//  Read 0x0002 and 0x1000 -> rvalid_o=1, err_o=1, rdata_o=0; write be_i=4'b0010 to 0x4000 with
//   wdata 0x0000AB00 -> only mtimecmp[15:8]=AB.
//  TICK_DIV=4: mtime increments every 4th cycle; assert rstn_i low mid-request -> all outputs 0
//   immediately, no rvalid_o after release.

Source files
------------

// File: rtl/jedro_1_clint.sv
// Core-local interruptor for a single hart: memory-mapped mtime/mtimecmp timer and msip
// software-interrupt register, exposed as a zero-wait-state data-bus slave.
module jedro_1_clint #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TICK_DIV   = 1
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    req_i,
    input  logic                    we_i,
    input  logic [15:0]             addr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [3:0]              be_i,
    output logic                    rvalid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    err_o,
    output logic                    timer_irq_o,
    output logic                    sw_irq_o
);
    localparam int unsigned PRESC_W = 16;
    localparam int unsigned TIME_W  = 64;
    localparam logic [15:0] ADDR_MSIP   = 16'h0000;
    localparam logic [15:0] ADDR_CMP_LO = 16'h4000;
    localparam logic [15:0] ADDR_CMP_HI = 16'h4004;
    localparam logic [15:0] ADDR_MT_LO  = 16'hBFF8;
    localparam logic [15:0] ADDR_MT_HI  = 16'hBFFC;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

    logic [TIME_W-1:0]     r_mtime;
    logic [TIME_W-1:0]     r_mtimecmp;
    logic                  r_msip;
    logic [PRESC_W-1:0]    r_presc;

    logic                  w_sel_msip, w_sel_cmp_lo, w_sel_cmp_hi, w_sel_mt_lo, w_sel_mt_hi;
    logic                  w_mapped, w_wr, w_tick;
    logic [TIME_W-1:0]     w_mtime_nxt;
    logic [TIME_W-1:0]     w_mtimecmp_nxt;
    logic                  w_msip_nxt;
    logic [PRESC_W-1:0]    w_presc_nxt;
    logic [DATA_WIDTH-1:0] w_rdata;

    function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  be);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return res;
    endfunction

    // Address decode; exact-match compares also reject misaligned offsets.
    always_comb begin
        w_sel_msip   = (addr_i == ADDR_MSIP);
        w_sel_cmp_lo = (addr_i == ADDR_CMP_LO);
        w_sel_cmp_hi = (addr_i == ADDR_CMP_HI);
        w_sel_mt_lo  = (addr_i == ADDR_MT_LO);
        w_sel_mt_hi  = (addr_i == ADDR_MT_HI);
        w_mapped     = w_sel_msip | w_sel_cmp_lo | w_sel_cmp_hi | w_sel_mt_lo | w_sel_mt_hi;
        w_wr         = req_i & we_i & w_mapped;
    end

    // Next-state for timer, compare, msip and prescaler; a bus write to mtime beats the tick.
    always_comb begin
        w_tick         = (r_presc == PRESC_LAST);
        w_presc_nxt    = w_tick ? '0 : r_presc + PRESC_W'(1);
        w_msip_nxt     = r_msip;
        w_mtimecmp_nxt = r_mtimecmp;
        w_mtime_nxt    = w_tick ? r_mtime + TIME_W'(1) : r_mtime;

        if (w_wr && w_sel_msip && be_i[0]) begin
            w_msip_nxt = wdata_i[0];
        end
        if (w_wr && w_sel_cmp_lo) begin
            w_mtimecmp_nxt[31:0] = f_merge(r_mtimecmp[31:0], wdata_i, be_i);
        end
        if (w_wr && w_sel_cmp_hi) begin
            w_mtimecmp_nxt[63:32] = f_merge(r_mtimecmp[63:32], wdata_i, be_i);
        end
        if (w_wr && w_sel_mt_lo) begin
            w_mtime_nxt = {r_mtime[63:32], f_merge(r_mtime[31:0], wdata_i, be_i)};
        end
        if (w_wr && w_sel_mt_hi) begin
            w_mtime_nxt = {f_merge(r_mtime[63:32], wdata_i, be_i), r_mtime[31:0]};
        end
    end

    // Read mux returns pre-update register contents.
    always_comb begin
        w_rdata = '0;
        if (w_sel_msip) begin
            w_rdata = DATA_WIDTH'(r_msip);
        end else if (w_sel_cmp_lo) begin
            w_rdata = r_mtimecmp[31:0];
        end else if (w_sel_cmp_hi) begin
            w_rdata = r_mtimecmp[63:32];
        end else if (w_sel_mt_lo) begin
            w_rdata = r_mtime[31:0];
        end else if (w_sel_mt_hi) begin
            w_rdata = r_mtime[63:32];
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_mtime     <= '0;
            r_mtimecmp  <= '1;
            r_msip      <= 1'b0;
            r_presc     <= '0;
            rvalid_o    <= 1'b0;
            rdata_o     <= '0;
            err_o       <= 1'b0;
            timer_irq_o <= 1'b0;
            sw_irq_o    <= 1'b0;
        end else begin
            r_mtime     <= w_mtime_nxt;
            r_mtimecmp  <= w_mtimecmp_nxt;
            r_msip      <= w_msip_nxt;
            r_presc     <= w_presc_nxt;
            rvalid_o    <= req_i;
            rdata_o     <= (req_i && !we_i && w_mapped) ? w_rdata : '0;
            err_o       <= req_i & ~w_mapped;
            timer_irq_o <= (w_mtime_nxt >= w_mtimecmp_nxt);
            sw_irq_o    <= r_msip;
        end
    end
endmodule

// File: tb/tb_jedro_1_clint.sv
// Scoreboard bench for jedro_1_clint: TICK_DIV=1 and TICK_DIV=4 instances share the bus wires.
module tb_jedro_1_clint;
    typedef struct {
        logic [31:0] data;
        logic        err;
        int unsigned tol;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn1, rstn4, req1, req4, we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        rvalid1, err1, tirq1, sirq1;
    logic        rvalid4, err4, tirq4, sirq4;
    logic [31:0] rdata1, rdata4;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q1[$];
    exp_t q4[$];
    exp_t e1, e4;

    always #5 clk = ~clk;

    jedro_1_clint #(.DATA_WIDTH(32), .TICK_DIV(1)) dut1 (
        .clk_i(clk), .rstn_i(rstn1), .req_i(req1), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .be_i(be), .rvalid_o(rvalid1), .rdata_o(rdata1), .err_o(err1),
        .timer_irq_o(tirq1), .sw_irq_o(sirq1));

    jedro_1_clint #(.DATA_WIDTH(32), .TICK_DIV(4)) dut4 (
        .clk_i(clk), .rstn_i(rstn4), .req_i(req4), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .be_i(be), .rvalid_o(rvalid4), .rdata_o(rdata4), .err_o(err4),
        .timer_irq_o(tirq4), .sw_irq_o(sirq4));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic bit in_tol(input logic [31:0] act, input logic [31:0] exp,
                                  input int unsigned tol);
        logic [31:0] d;
        d = (act >= exp) ? act - exp : exp - act;
        return (d <= tol);
    endfunction

    // Monitors: pop one expectation per response and compare.
    always @(negedge clk) begin
        if (rvalid1) begin
            n_cmp++;
            if (q1.size() == 0) begin
                n_bad++;
                $display("FAIL dut1_unexpected_rvalid: got rdata %h err %b expected no response", rdata1, err1);
            end else begin
                e1 = q1.pop_front();
                if (err1 !== e1.err || !in_tol(rdata1, e1.data, e1.tol)) begin
                    n_bad++;
                    $display("FAIL %s: got rdata %h err %b expected rdata %h (+/-%0d) err %b",
                             e1.name, rdata1, err1, e1.data, e1.tol, e1.err);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rvalid4) begin
            n_cmp++;
            if (q4.size() == 0) begin
                n_bad++;
                $display("FAIL dut4_unexpected_rvalid: got rdata %h err %b expected no response", rdata4, err4);
            end else begin
                e4 = q4.pop_front();
                if (err4 !== e4.err || !in_tol(rdata4, e4.data, e4.tol)) begin
                    n_bad++;
                    $display("FAIL %s: got rdata %h err %b expected rdata %h (+/-%0d) err %b",
                             e4.name, rdata4, err4, e4.data, e4.tol, e4.err);
                end
            end
        end
    end

    // One bus access issued at a negedge; returns at the following negedge.
    task automatic bus(input bit to4, input logic w, input logic [15:0] a, input logic [31:0] d,
                       input logic [3:0] b, input logic [31:0] ed, input logic ee,
                       input int unsigned tol, input string nm);
        exp_t e;
        e.data = ed; e.err = ee; e.tol = tol; e.name = nm;
        we = w; addr = a; wdata = d; be = b;
        if (to4) begin
            q4.push_back(e);
            req4 = 1'b1;
        end else begin
            q1.push_back(e);
            req1 = 1'b1;
        end
        @(negedge clk);
        req1 = 1'b0; req4 = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
    endtask

    initial begin
        rstn1 = 1'b0; rstn4 = 1'b0; req1 = 1'b0; req4 = 1'b0;
        we = 1'b0; addr = '0; wdata = '0; be = '0;
        repeat (3) @(negedge clk);
        chk("rst_outputs", {rvalid1, err1, tirq1, sirq1, rdata1}, '0);

        // mtime counts from zero after release
        rstn1 = 1'b1;
        repeat (10) @(negedge clk);
        bus(0, 0, 16'hBFF8, 0, 4'h0, 32'd10, 0, 1, "mtime_after_10");
        chk("tirq_idle", 64'(tirq1), 64'd0);

        // Timer compare
        bus(0, 1, 16'hBFF8, 32'd0,  4'hF, 0, 0, 0, "wr_mtime_lo0");
        bus(0, 1, 16'h4000, 32'd20, 4'hF, 0, 0, 0, "wr_cmp_lo20");
        bus(0, 1, 16'h4004, 32'd0,  4'hF, 0, 0, 0, "wr_cmp_hi0");
        repeat (12) @(negedge clk);
        chk("tirq_before_match", 64'(tirq1), 64'd0);
        repeat (8) @(negedge clk);
        chk("tirq_after_match", 64'(tirq1), 64'd1);
        bus(0, 1, 16'h4004, 32'd1, 4'hF, 0, 0, 0, "wr_cmp_hi1");
        chk("tirq_cmp_raised", 64'(tirq1), 64'd0);
        bus(0, 0, 16'h4004, 0, 4'h0, 32'd1, 0, 0, "rd_cmp_hi");

        // Carry and 64-bit wrap
        bus(0, 1, 16'hBFFC, 32'd0,          4'hF, 0, 0, 0, "wr_mtime_hi0");
        bus(0, 1, 16'hBFF8, 32'hFFFF_FFFF,  4'hF, 0, 0, 0, "wr_mtime_lo_ones");
        bus(0, 0, 16'hBFF8, 0, 4'h0, 32'hFFFF_FFFF, 0, 0, "rd_lo_pre_carry");
        bus(0, 0, 16'hBFFC, 0, 4'h0, 32'd1, 0, 0, "rd_hi_post_carry");
        bus(0, 0, 16'hBFF8, 0, 4'h0, 32'd1, 0, 0, "rd_lo_post_carry");
        chk("tirq_below_cmp", 64'(tirq1), 64'd0);
        bus(0, 1, 16'h4004, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, "wr_cmp_hi_ones");
        bus(0, 1, 16'h4000, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, "wr_cmp_lo_ones");
        bus(0, 1, 16'hBFFC, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, "wr_mtime_hi_ones");
        bus(0, 1, 16'hBFF8, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, "wr_mtime_lo_ones2");
        chk("tirq_at_max", 64'(tirq1), 64'd1);
        bus(0, 0, 16'hBFFC, 0, 4'h0, 32'hFFFF_FFFF, 0, 0, "rd_hi_at_max");
        chk("tirq_after_wrap", 64'(tirq1), 64'd0);
        bus(0, 0, 16'hBFFC, 0, 4'h0, 32'd0, 0, 0, "rd_hi_wrapped");
        bus(0, 0, 16'hBFF8, 0, 4'h0, 32'd1, 0, 0, "rd_lo_wrapped");

        // Software interrupt
        bus(0, 1, 16'h0000, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, "wr_msip1");
        @(negedge clk);
        chk("sw_irq_set", 64'(sirq1), 64'd1);
        bus(0, 0, 16'h0000, 0, 4'h0, 32'd1, 0, 0, "rd_msip1");
        bus(0, 1, 16'h0000, 32'd0, 4'hF, 0, 0, 0, "wr_msip0");
        @(negedge clk);
        chk("sw_irq_clr", 64'(sirq1), 64'd0);
        bus(0, 0, 16'h0000, 0, 4'h0, 32'd0, 0, 0, "rd_msip0");

        // Errors and byte enables
        bus(0, 0, 16'h0002, 0, 4'h0, 32'd0, 1, 0, "rd_misaligned");
        bus(0, 0, 16'h1000, 0, 4'h0, 32'd0, 1, 0, "rd_unmapped");
        bus(0, 1, 16'h4000, 32'h1122_3344, 4'hF, 0, 0, 0, "wr_cmp_lo_full");
        bus(0, 1, 16'h4000, 32'h0000_AB00, 4'b0010, 0, 0, 0, "wr_cmp_lo_byte1");
        bus(0, 0, 16'h4000, 0, 4'h0, 32'h1122_AB44, 0, 0, "rd_cmp_lo_byte1");
        bus(0, 1, 16'h4000, 32'hFFFF_FFFF, 4'h0, 0, 0, 0, "wr_cmp_lo_be0");
        bus(0, 1, 16'h4003, 32'hFFFF_FFFF, 4'hF, 0, 1, 0, "wr_misaligned");
        bus(0, 0, 16'h4000, 0, 4'h0, 32'h1122_AB44, 0, 0, "rd_cmp_lo_unchanged");

        // TICK_DIV=4 instance
        rstn4 = 1'b1;
        repeat (8) @(negedge clk);
        bus(1, 0, 16'hBFF8, 0, 4'h0, 32'd2, 0, 0, "div4_mtime_2");
        repeat (3) @(negedge clk);
        bus(1, 0, 16'hBFF8, 0, 4'h0, 32'd3, 0, 0, "div4_mtime_3");
        bus(1, 1, 16'h0000, 32'd1, 4'hF, 0, 0, 0, "div4_wr_msip");
        @(negedge clk);
        chk("div4_sw_irq", 64'(sirq4), 64'd1);

        // Reset lands while a read response is on the bus
        we = 1'b0; addr = 16'h0000; req4 = 1'b1;
        @(posedge clk);
        #1;
        chk("div4_rvalid_before_rst", 64'(rvalid4), 64'd1);
        rstn4 = 1'b0;
        #1;
        chk("div4_outputs_in_rst", {rvalid4, err4, tirq4, sirq4, rdata4}, '0);
        @(negedge clk);
        req4 = 1'b0;
        @(negedge clk);
        rstn4 = 1'b1;
        repeat (4) @(negedge clk);
        chk("div4_sw_irq_after_rst", 64'(sirq4), 64'd0);

        chk("q1_drained", 64'(q1.size()), 64'd0);
        chk("q4_drained", 64'(q4.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
